pc_tx_word_serialiser: RTL and testbench

//  PC_TX end of the data router's output path: accepts one 32-bit word plus a one-cycle start

---
 rtl/pc_tx_word_serialiser_if.sv | 27 ++
 rtl/pc_tx_word_serialiser.sv | 157 +++++++++++++++
 tb/tb_pc_tx_word_serialiser.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_tx_word_serialiser_if.sv
// Router-side bundle for the PC_TX word serialiser: word/start command in, status and serial line out.
interface pc_tx_word_serialiser_if;
  logic [31:0] word;
  logic        next_cmd;
  logic        serial_is_busy;
  logic        word_done;
  logic        overrun_err;
  logic        uart_tx;

  modport master (
    output word,
    output next_cmd,
    input  serial_is_busy,
    input  word_done,
    input  overrun_err,
    input  uart_tx
  );

  modport slave (
    input  word,
    input  next_cmd,
    output serial_is_busy,
    output word_done,
    output overrun_err,
    output uart_tx
  );
endinterface

// File: rtl/pc_tx_word_serialiser.sv
// Sends a 32-bit word as four UART bytes, MSB byte first, LSB bit first (8N1).
// Define PC_TX_PARITY_EN to insert an even-parity bit per byte (8E1).
module pc_tx_word_serialiser #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input logic                   i_clock,
  input logic                   i_reset_n,
  pc_tx_word_serialiser_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef PC_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        baud_end;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_nxt;

  // The byte on the wire always sits in the top eight bits of the shift register.
  assign cur_byte = shift_q[31:24];
  assign baud_end = (baud_q == BaudLast);
  assign bit_nxt  = bit_q + 3'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q != StIdle) begin
      baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
      // A command while a word is in flight is dropped and flagged.
      err_d  = bus.next_cmd;
    end

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = 16'd0;
        bit_d  = 3'd0;
        byte_d = 2'd0;
        if (bus.next_cmd) begin
          shift_d = bus.word;
          state_d = StStart;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (baud_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
`ifdef PC_TX_PARITY_EN
            state_d = StParity;
            tx_d    = ^cur_byte;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end
      end
`ifdef PC_TX_PARITY_EN
      StParity: begin
        if (baud_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_end) begin
          if (byte_q == 2'd3) begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // No inter-byte gap: next start bit follows the stop bit directly.
            byte_d  = byte_q + 2'd1;
            shift_d = {shift_q[23:0], 8'h00};
            state_d = StStart;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shift_q <= 32'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.uart_tx        = tx_q;
  assign bus.serial_is_busy = busy_q;
  assign bus.word_done      = done_q;
  assign bus.overrun_err    = err_q;

endmodule

// File: tb/tb_pc_tx_word_serialiser.sv
// Scoreboard bench for pc_tx_word_serialiser: a UART receiver process checks every frame
// against expected frames queued by the stimulus.
module tb_pc_tx_word_serialiser;

  localparam int unsigned CPB = 4;
`ifdef PC_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int unsigned WORD_CYC = 4 * FB * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_tx_word_serialiser_if bus ();

  pc_tx_word_serialiser #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Frame as seen on the wire, bit 0 = start bit.
  function automatic logic [10:0] frame(input logic [7:0] b);
`ifdef PC_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic push_bytes(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(frame(w[31-8*i -: 8]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.word_done === 1'b1) done_cnt++;
    if (bus.overrun_err === 1'b1) err_cnt++;
  end

  // Receiver: samples mid-bit, abandons a frame if reset is seen during it.
  initial begin : rx
    logic [10:0] got;
    logic [10:0] e;
    logic        abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.uart_tx === 1'b0) begin
        got   = '0;
        abort = 1'b0;
        for (int c = 0; c <= int'((FB - 1) * CPB + CPB / 2); c++) begin
          if (c != 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            abort = 1'b1;
            break;
          end
          if (c % CPB == CPB / 2) got[c/CPB] = bus.uart_tx;
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected_frame got=0x%0h exp=none", got);
          end else begin
            e = exp_q.pop_front();
            check("rx_frame", 32'(got), 32'(e));
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    bus.word     = w;
    bus.next_cmd = 1'b1;
    tick();
    bus.next_cmd = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.word_done !== 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    check(name, 32'(bus.word_done), 32'd1);
  endtask

  task automatic run_word(input logic [31:0] w, input string name);
    int n;
    int d0;
    push_bytes(w, 4);
    d0 = done_cnt;
    send(w);
    check({name, "_first_tx"}, 32'({bus.uart_tx, bus.serial_is_busy}), 32'b01);
    bus.word = ~w;
    n = 0;
    while (bus.serial_is_busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    check({name, "_busy_len"}, 32'(n), 32'(WORD_CYC));
    check({name, "_done_cycle"}, 32'({bus.word_done, bus.uart_tx}), 32'b11);
    tick();
    check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_done_low"}, 32'(bus.word_done), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int d0;
    int e0;
    bus.word     = '0;
    bus.next_cmd = 1'b0;

    // 1: reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.word     = $urandom;
      bus.next_cmd = 1'($urandom_range(0, 1));
      tick();
      check("reset_outputs",
            32'({bus.uart_tx, bus.serial_is_busy, bus.word_done, bus.overrun_err}), 32'b1000);
    end
    bus.next_cmd = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 32'({bus.uart_tx, bus.serial_is_busy}), 32'b10);

    // 2: single word
    run_word(32'hA53C_0F81, "single");

    // 3: back-to-back, second command in the done cycle
    push_bytes(32'h1234_5678, 4);
    send(32'h1234_5678);
    wait_done("b2b_first_done");
    push_bytes(32'h0000_0000, 4);
    send(32'h0000_0000);
    check("b2b_immediate_start", 32'({bus.uart_tx, bus.serial_is_busy}), 32'b01);
    wait_done("b2b_second_done");
    tick();

    // 4: overrun at cycle 20 of a word in flight
    push_bytes(32'h5AC3_E718, 4);
    send(32'h5AC3_E718);
    repeat (19) tick();
    e0 = err_cnt;
    send(32'hFFFF_FFFF);
    check("overrun_pulse", 32'(bus.overrun_err), 32'd1);
    tick();
    check("overrun_one_cycle", 32'(bus.overrun_err), 32'd0);
    wait_done("overrun_word_done");
    tick();
    check("overrun_count", 32'(err_cnt - e0), 32'd1);

    // 5: reset during byte 2, data bit 3
    push_bytes(32'hC0FF_EE11, 1);
    send(32'hC0FF_EE11);
    repeat (FB * CPB + 4 * CPB + 1) tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    tick();
    check("midreset_line", 32'({bus.uart_tx, bus.serial_is_busy}), 32'b10);
    rst_n = 1'b1;
    repeat (WORD_CYC) tick();
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    run_word(32'h600D_F00D, "after_reset");

`ifdef PC_TX_PARITY_EN
    // 6: parity bits 1,1,1,0
    run_word(32'h0101_0100, "parity");
`endif

    repeat (4) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
